// File: rtl/acog_div.sv
// Non-restoring iterative divider, one quotient bit per clock, unsigned or signed (truncating).
// done_o pulses WIDTH+2 clocks after the accepting edge (2 for a zero divisor); start_in is ignored while busy.
module acog_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] s_in,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             div_zero_o,
  output logic             ovf_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_ITER = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d, s_q, s_d, smag_q, smag_d, q_q, q_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [WIDTH:0]   r_q, r_d;
  logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] d_mag, s_mag;
  logic [WIDTH:0]   r_shift, r_step, r_fix;

  assign d_mag   = (sgn_q && d_q[WIDTH-1]) ? -d_q : d_q;
  assign s_mag   = (sgn_q && s_q[WIDTH-1]) ? -s_q : s_q;
  // R is one bit wider than the operands; the shifted value may wrap, but every
  // post-step remainder lies in [-|S|, |S|) so modular arithmetic stays exact.
  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign r_step  = r_q[WIDTH] ? r_shift + {1'b0, smag_q} : r_shift - {1'b0, smag_q};
  assign r_fix   = r_q[WIDTH] ? r_q + {1'b0, smag_q} : r_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    s_d     = s_q;
    sgn_d   = sgn_q;
    smag_d  = smag_q;
    q_d     = q_q;
    r_d     = r_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          d_d     = d_in;
          s_d     = s_in;
          sgn_d   = signed_in;
          busy_d  = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        smag_d  = s_mag;
        q_d     = d_mag;
        r_d     = '0;
        cnt_d   = '0;
        qneg_d  = sgn_q & (d_q[WIDTH-1] ^ s_q[WIDTH-1]);
        rneg_d  = sgn_q & d_q[WIDTH-1];
        zero_d  = (s_q == '0);
        state_d = (s_q == '0) ? ST_FIX : ST_ITER;
      end
      ST_ITER: begin
        r_d   = r_step;
        q_d   = {q_q[WIDTH-2:0], ~r_step[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = ST_FIX;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = d_q;
          dz_d   = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          quot_d = qneg_q ? -q_q : q_q;
          rem_d  = rneg_q ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
          dz_d   = 1'b0;
          ovf_d  = sgn_q && (d_q == MIN_NEG) && (&s_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      s_q     <= '0;
      sgn_q   <= 1'b0;
      smag_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      s_q     <= s_d;
      sgn_q   <= sgn_d;
      smag_q  <= smag_d;
      q_q     <= q_d;
      r_q     <= r_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quot_o     = quot_q;
  assign rem_o      = rem_q;
  assign div_zero_o = dz_q;
  assign ovf_o      = ovf_q;
endmodule

// File: tb/tb_acog_div.sv
// Self-checking bench for acog_div: directed cases, timing/reset scenarios and
// random operands compared against a plain-arithmetic division model.
module tb_acog_div;
  localparam int W = 32;

  logic         clk_in = 1'b0;
  logic         reset_in, start_in, signed_in;
  logic [W-1:0] d_in, s_in;
  logic         busy_o, done_o, div_zero_o, ovf_o;
  logic [W-1:0] quot_o, rem_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  acog_div #(.WIDTH(W)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .signed_in(signed_in),
    .d_in(d_in), .s_in(s_in), .busy_o(busy_o), .done_o(done_o), .quot_o(quot_o),
    .rem_o(rem_o), .div_zero_o(div_zero_o), .ovf_o(ovf_o)
  );

  // Reference: 64-bit arithmetic truncating division, special-cased divide by zero.
  task automatic model(input logic sgn, input logic [31:0] d, input logic [31:0] s,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov, output int lat);
    longint dd, ss;
    if (s == 32'h0) begin
      q = 32'hFFFFFFFF; r = d; dz = 1'b1; ov = 1'b0; lat = 2;
    end else begin
      dd = sgn ? longint'({{32{d[31]}}, d}) : longint'({32'h0, d});
      ss = sgn ? longint'({{32{s[31]}}, s}) : longint'({32'h0, s});
      q = 32'(dd / ss);
      r = 32'(dd % ss);
      dz = 1'b0;
      ov = sgn && (d == 32'h80000000) && (s == 32'hFFFFFFFF);
      lat = 34;
    end
  endtask

  // Drive a start pulse; inputs are scrambled right after the accept edge.
  task automatic issue(input logic sgn, input logic [31:0] d, input logic [31:0] s);
    start_in = 1'b1; signed_in = sgn; d_in = d; s_in = s;
    @(posedge clk_in); #1;
    start_in = 1'b0; signed_in = 1'($urandom); d_in = $urandom; s_in = $urandom;
  endtask

  // Counts clocks after the accept edge until done_o; lat = -1 on timeout.
  task automatic wait_done(input int poke_at, output int lat, output int busyc);
    lat = -1; busyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      if (c == poke_at) begin start_in = 1'b1; d_in = $urandom; s_in = $urandom; end
      else start_in = 1'b0;
      if (done_o) begin lat = c; break; end
      if (busy_o) busyc++;
    end
  endtask

  task automatic do_op(input logic sgn, input logic [31:0] d, input logic [31:0] s, input int poke_at,
                       output int lat, output int busyc, output logic [31:0] eq, output logic [31:0] er,
                       output logic edz, output logic eov, output int elat);
    model(sgn, d, s, eq, er, edz, eov, elat);
    issue(sgn, d, s);
    wait_done(poke_at, lat, busyc);
  endtask

  task automatic test_reset();
    reset_in = 1'b1; start_in = 1'b0; signed_in = 1'b0; d_in = '0; s_in = '0;
    repeat (3) @(negedge clk_in);
    checks++; if ({busy_o, done_o, div_zero_o, ovf_o} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got %b want 0000", {busy_o, done_o, div_zero_o, ovf_o}); end
    checks++; if ({quot_o, rem_o} !== 64'h0) begin errors++;
      $display("FAIL reset_data got %h/%h want 0/0", quot_o, rem_o); end
    reset_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_unsigned();
    logic [31:0] dv [3] = '{32'd100, 32'hFFFFFFFF, 32'h3};
    logic [31:0] sv [3] = '{32'd7, 32'h1, 32'hFFFFFFFD};
    logic [31:0] eq, er; logic edz, eov; int lat, busyc, elat;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, dv[i], sv[i], 0, lat, busyc, eq, er, edz, eov, elat);
      checks++; if (quot_o !== eq) begin errors++; $display("FAIL unsigned_quot[%0d] got %h want %h", i, quot_o, eq); end
      checks++; if (rem_o !== er) begin errors++; $display("FAIL unsigned_rem[%0d] got %h want %h", i, rem_o, er); end
      checks++; if ({div_zero_o, ovf_o} !== {edz, eov}) begin errors++;
        $display("FAIL unsigned_flags[%0d] got %b want %b", i, {div_zero_o, ovf_o}, {edz, eov}); end
      checks++; if (lat != elat || busyc != elat - 1 || busy_o !== 1'b0) begin errors++;
        $display("FAIL unsigned_timing[%0d] got lat %0d busy %0d want %0d/%0d", i, lat, busyc, elat, elat - 1); end
    end
  endtask

  task automatic test_signed();
    logic [31:0] dv [2] = '{32'hFFFFFFF9, 32'h7};
    logic [31:0] sv [2] = '{32'h2, 32'hFFFFFFFE};
    logic [31:0] eq, er; logic edz, eov; int lat, busyc, elat;
    for (int i = 0; i < 2; i++) begin
      do_op(1'b1, dv[i], sv[i], 0, lat, busyc, eq, er, edz, eov, elat);
      checks++; if ({quot_o, rem_o} !== {eq, er}) begin errors++;
        $display("FAIL signed_qr[%0d] got %h/%h want %h/%h", i, quot_o, rem_o, eq, er); end
      checks++; if ({div_zero_o, ovf_o} !== {edz, eov} || lat != elat) begin errors++;
        $display("FAIL signed_flags_lat[%0d] got %b lat %0d want %b lat %0d", i, {div_zero_o, ovf_o}, lat, {edz, eov}, elat); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] eq, er; logic edz, eov; int lat, busyc, elat;
    for (int i = 0; i < 2; i++) begin
      do_op(1'(i), 32'h5, 32'h0, 0, lat, busyc, eq, er, edz, eov, elat);
      checks++; if ({quot_o, rem_o} !== {eq, er}) begin errors++;
        $display("FAIL divzero_qr[%0d] got %h/%h want %h/%h", i, quot_o, rem_o, eq, er); end
      checks++; if ({div_zero_o, ovf_o} !== {edz, eov}) begin errors++;
        $display("FAIL divzero_flags[%0d] got %b want %b", i, {div_zero_o, ovf_o}, {edz, eov}); end
      checks++; if (lat != elat || busyc != elat - 1) begin errors++;
        $display("FAIL divzero_lat[%0d] got %0d busy %0d want %0d", i, lat, busyc, elat); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] eq, er; logic edz, eov; int lat, busyc, elat;
    for (int i = 0; i < 2; i++) begin
      do_op(1'(1 - i), 32'h80000000, 32'hFFFFFFFF, 0, lat, busyc, eq, er, edz, eov, elat);
      checks++; if ({quot_o, rem_o} !== {eq, er}) begin errors++;
        $display("FAIL ovf_qr[%0d] got %h/%h want %h/%h", i, quot_o, rem_o, eq, er); end
      checks++; if ({div_zero_o, ovf_o} !== {edz, eov} || lat != elat) begin errors++;
        $display("FAIL ovf_flags[%0d] got %b lat %0d want %b lat %0d", i, {div_zero_o, ovf_o}, lat, {edz, eov}, elat); end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] eq, er; logic edz, eov; int lat, busyc, elat;
    do_op(1'b0, 32'd100, 32'd7, 10, lat, busyc, eq, er, edz, eov, elat);
    checks++; if ({quot_o, rem_o} !== {eq, er} || lat != elat) begin errors++;
      $display("FAIL ignore_start got %h/%h lat %0d want %h/%h lat %0d", quot_o, rem_o, lat, eq, er, elat); end
    @(negedge clk_in);
    checks++; if ({busy_o, done_o} !== 2'b00) begin errors++;
      $display("FAIL after_done got busy/done %b want 00", {busy_o, done_o}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] eq, er; logic edz, eov; int lat, busyc, elat;
    issue(1'b1, 32'hFFFFFFF9, 32'h2);
    repeat (10) @(negedge clk_in);
    reset_in = 1'b1; #1;
    checks++; if ({busy_o, done_o, div_zero_o, ovf_o, quot_o, rem_o} !== 68'h0) begin errors++;
      $display("FAIL reset_mid got busy %b quot %h rem %h", busy_o, quot_o, rem_o); end
    @(negedge clk_in); reset_in = 1'b0;
    @(negedge clk_in);
    do_op(1'b0, 32'd100, 32'd7, 0, lat, busyc, eq, er, edz, eov, elat);
    checks++; if ({quot_o, rem_o} !== {eq, er} || lat != elat || busyc != elat - 1) begin errors++;
      $display("FAIL post_reset got %h/%h lat %0d want %h/%h lat %0d", quot_o, rem_o, lat, eq, er, elat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eq, er; logic edz, eov; int lat, busyc, elat;
    do_op(1'b1, 32'h7, 32'hFFFFFFFE, 0, lat, busyc, eq, er, edz, eov, elat);
    checks++; if ({quot_o, rem_o} !== {eq, er} || lat != elat) begin errors++;
      $display("FAIL b2b_first got %h/%h lat %0d want %h/%h lat %0d", quot_o, rem_o, lat, eq, er, elat); end
    do_op(1'b0, 32'd1000, 32'd33, 0, lat, busyc, eq, er, edz, eov, elat);
    checks++; if ({quot_o, rem_o} !== {eq, er} || lat != elat) begin errors++;
      $display("FAIL b2b_second got %h/%h lat %0d want %h/%h lat %0d", quot_o, rem_o, lat, eq, er, elat); end
  endtask

  task automatic test_random();
    logic [31:0] d, s, eq, er; logic sgn, edz, eov; int lat, busyc, elat, k;
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      k = $urandom_range(0, 9);
      s = (k == 0) ? 32'h0 : (k == 1) ? 32'h1 : (k == 2) ? 32'hFFFFFFFF :
          (k == 3) ? 32'($urandom_range(1, 15)) : $urandom;
      k = $urandom_range(0, 7);
      d = (k == 0) ? 32'h80000000 : (k == 1) ? 32'($urandom_range(0, 200)) : $urandom;
      do_op(sgn, d, s, 0, lat, busyc, eq, er, edz, eov, elat);
      checks++; if ({quot_o, rem_o, div_zero_o, ovf_o} !== {eq, er, edz, eov} || lat != elat) begin errors++;
        $display("FAIL random[%0d] s%0d %h/%h got %h/%h %b%b lat %0d want %h/%h %b%b lat %0d",
                 i, sgn, d, s, quot_o, rem_o, div_zero_o, ovf_o, lat, eq, er, edz, eov, elat); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
